// File: rtl/activation_scheduler.sv
// Shared LUT + linear-interpolation activation engine, time-multiplexed
// across all neurons of a layer through a 2-stage pipeline.
module activation_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int DW        = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_addr,
    input  logic [DW-1:0]             cfg_data,
    output logic                      cfg_rej,
    input  logic                      start,
    input  logic [N_NEURONS*DW-1:0]   z_vec,
    output logic                      busy,
    output logic                      done,
    output logic [N_NEURONS*DW-1:0]   a_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(N_NEURONS - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [DW-1:0]             r_tbl [16];
    logic [N_NEURONS*DW-1:0]   r_z;
    logic [4:0]                r_idx;
    logic                      w_issue;

    logic                      r_s1_vld;
    logic                      r_s1_last;
    logic [4:0]                r_s1_idx;
    logic [DW-1:0]             r_s1_base;
    logic [DW-1:0]             r_s1_next;
    logic [3:0]                r_s1_rem;

    logic                      r_s2_vld;
    logic                      r_s2_last;
    logic [N_NEURONS*DW-1:0]   r_a;

    logic [DW-1:0]             w_z;
    logic [3:0]                w_addr;
    logic [3:0]                w_nxa;
    logic signed [8:0]         w_diff;
    logic signed [12:0]        w_diff13;
    logic signed [12:0]        w_rem13;
    logic signed [12:0]        w_prod;
    logic signed [9:0]         w_y;
    logic [DW-1:0]             w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_idx == LAST) w_next = S_DRAIN;
            S_DRAIN: if (r_s2_vld && r_s2_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done    = (r_state == S_DONE);
    assign cfg_rej = cfg_we && busy;
    assign w_issue = (r_state == S_RUN);
    assign a_vec   = r_a;

    // Table resets to an identity ramp so an unconfigured block passes z through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_tbl[i] <= {4'(i), 4'b0000};
            r_z   <= '0;
            r_idx <= '0;
        end else begin
            if (cfg_we && !busy) r_tbl[cfg_addr] <= cfg_data;
            if (r_state == S_IDLE && start) begin
                r_z   <= z_vec;
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    always_comb begin
        w_z = '0;
        for (int k = 0; k < N_NEURONS; k++)
            if (r_idx == 5'(k)) w_z = r_z[k*DW +: DW];
    end

    assign w_addr = w_z[7:4];
    // Entry 7 is the top of the positive range; do not interpolate toward -128
    assign w_nxa  = (w_addr == 4'd7) ? 4'd7 : w_addr + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_base <= '0;
            r_s1_next <= '0;
            r_s1_rem  <= '0;
        end else begin
            r_s1_vld  <= w_issue;
            r_s1_last <= w_issue && (r_idx == LAST);
            r_s1_idx  <= r_idx;
            r_s1_base <= r_tbl[w_addr];
            r_s1_next <= r_tbl[w_nxa];
            r_s1_rem  <= w_z[3:0];
        end
    end

    assign w_diff   = {r_s1_next[7], r_s1_next} - {r_s1_base[7], r_s1_base};
    assign w_diff13 = 13'(w_diff);
    assign w_rem13  = {9'b0, r_s1_rem};
    assign w_prod   = w_diff13 * w_rem13;
    assign w_y      = {{2{r_s1_base[7]}}, r_s1_base}
                    + {w_prod[12], w_prod[12:4]};

    always_comb begin
        if (w_y > 10'sd127)       w_sat = 8'h7F;
        else if (w_y < -10'sd128) w_sat = 8'h80;
        else                      w_sat = w_y[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_a       <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_vld && r_s1_last;
            if (r_s1_vld) begin
                for (int k = 0; k < N_NEURONS; k++)
                    if (r_s1_idx == 5'(k)) r_a[k*DW +: DW] <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_activation_scheduler.sv
// Bench for activation_scheduler: vector table of runs, scoreboard queue
// of expected activation vectors, plus hand-written corner sequences.
module tb_activation_scheduler;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_rej;
    logic        start;
    logic [31:0] z_vec;
    logic        busy;
    logic        done;
    logic [31:0] a_vec;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] sb[$];

    activation_scheduler #(.N_NEURONS(4), .DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_rej  (cfg_rej),
        .start    (start),
        .z_vec    (z_vec),
        .busy     (busy),
        .done     (done),
        .a_vec    (a_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w0;
        logic [3:0]  a0;
        logic [7:0]  d0;
        bit          w1;
        logic [3:0]  a1;
        logic [7:0]  d1;
        logic [31:0] z;
        logic [31:0] ex;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        #1 check("rej_idle", 32'(cfg_rej), 32'd0);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // inj: write and start pulses during RUN; co_*: write alongside start
    task automatic run(input logic [31:0] z, input logic [31:0] ex,
                       input bit inj, input bit co_we,
                       input logic [3:0] co_a, input logic [7:0] co_d);
        int cyc;
        int bcnt;
        int dcnt;
        logic [31:0] e;
        @(negedge clk);
        start    = 1'b1;
        z_vec    = z;
        cfg_we   = co_we;
        cfg_addr = co_a;
        cfg_data = co_d;
        sb.push_back(ex);
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        z_vec  = ~z;
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 50) begin
            if (busy) bcnt++;
            if (inj && cyc == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'd0;
                cfg_data = 8'h00;
                #1 check("rej_busy", 32'(cfg_rej), 32'd1);
            end
            if (inj && cyc == 3) start = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
            start  = 1'b0;
            cyc++;
        end
        check("done_lat", 32'(cyc - 1), 32'd6);
        check("busy_cyc", 32'(bcnt), 32'd6);
        check("busy_at_done", 32'(busy), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("a_vec", a_vec, e);
        end else begin
            check("sb_empty", 32'd1, 32'd0);
        end
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("extra_done", 32'(dcnt), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        start    = 1'b0;
        z_vec    = '0;

        vt[0] = '{0, 0, 0, 0, 0, 0, 32'h3500FF80, 32'h3500FF80};
        vt[1] = '{0, 0, 0, 0, 0, 0, 32'h7F10F801, 32'h7010F801};
        vt[2] = '{0, 0, 0, 0, 0, 0, 32'h2A00F57F, 32'h10101010};
        vt[3] = '{1, 2, 8'h20, 1, 3, 8'h40, 32'h28202F10, 32'h30203E10};
        vt[4] = '{1, 2, 8'h7F, 1, 3, 8'h80, 32'h2F20301F, 32'h8F7F8078};
        vt[5] = '{1, 0, 8'h7F, 1, 1, 8'h7F, 32'h05000F3F, 32'h7F7F7F07};

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rej", 32'(cfg_rej), 32'd0);
        check("rst_a", a_vec, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 2)
                for (int t = 0; t < 16; t++) wr(4'(t), 8'h10);
            if (vt[i].w0) wr(vt[i].a0, vt[i].d0);
            if (vt[i].w1) wr(vt[i].a1, vt[i].d1);
            run(vt[i].z, vt[i].ex, 1'b0, 1'b0, 4'd0, 8'd0);
        end

        // rejected write and ignored start during a run; table must be intact
        run(32'h05000F3F, 32'h7F7F7F07, 1'b1, 1'b0, 4'd0, 8'd0);
        run(32'h05000F3F, 32'h7F7F7F07, 1'b0, 1'b0, 4'd0, 8'd0);

        // write in the start cycle is visible to that run
        run(32'h40304F00, 32'h5080147F, 1'b0, 1'b1, 4'd4, 8'h50);

        // asynchronous abort two cycles into a run
        @(negedge clk);
        start = 1'b1;
        z_vec = 32'h11223344;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_pre_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_a", a_vec, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(32'h3500FF80, 32'h3500FF80, 1'b0, 1'b0, 4'd0, 8'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
